// File: rtl/edge_arb_pkg.sv
// edge_arb_pkg
// Shared types for the edge event arbiter: detector and arbiter state
// encodings, plus the default channel count.
//
// No ports (package).

package edge_arb_pkg;

   localparam int unsigned EDGE_ARB_N_DEFAULT = 4;

   // Rising-edge detector states. Encoding 2'b11 is illegal and recovers to ZERO.
   typedef enum logic [1:0] {
      ZERO = 2'b00,
      EDG  = 2'b01,
      ONE  = 2'b10
   } det_state_e;

   // Arbiter states.
   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } arb_state_e;

endpackage : edge_arb_pkg

// File: rtl/edge_detect_cell.sv
// edge_detect_cell
// Moore rising-edge detector for one already-synchronised level input.
// tick_o is high for exactly one cycle after the first high sample that
// follows a low sample (or follows reset).
//
// state | meaning
// ------+----------------------------------------------
// ZERO  | last sample low (or just reset)
// EDG   | rising edge seen; tick_o asserted this cycle
// ONE   | level still high after the edge was reported
//
// Ports:
//   clk_i    system clock, rising edge
//   reset_i  synchronous active-high reset
//   level_i  level input, sampled on clk_i
//   tick_o   one-cycle rising-edge pulse (decoded from state)

module edge_detect_cell
   import edge_arb_pkg::*;
(
   input  logic clk_i,
   input  logic reset_i,
   input  logic level_i,
   output logic tick_o
);

   det_state_e state_q, state_d;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ZERO:    if (level_i)  state_d = EDG;
         EDG:     state_d = level_i ? ONE : ZERO;
         ONE:     if (!level_i) state_d = ZERO;
         default: state_d = ZERO;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ZERO;
      end else begin
         state_q <= state_d;
      end
   end

   assign tick_o = (state_q == EDG);

endmodule : edge_detect_cell

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter
// Turns rising edges on N level inputs into single events and hands them,
// one at a time, to a shared consumer over a valid/ready handshake.
// Each channel keeps a pending flag; a round-robin arbiter picks the next
// pending channel. Edges that arrive while a channel's previous event is
// still pending (and not being accepted) set a sticky overrun bit.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | nothing offered; pick next pending channel from rr pointer
// OFFER | ev_valid_o high, ev_id_o held until ev_ready_i
//
// Ports:
//   clk_i          system clock, rising edge
//   reset_i        synchronous active-high reset
//   level_i[N]     per-channel level inputs
//   ev_valid_o     event offered to consumer
//   ev_id_o[IDW]   channel index of offered event
//   ev_ready_i     consumer accepts when high together with ev_valid_o
//   overrun_o[N]   sticky per-channel lost-event flags
//   clr_overrun_i  clears all overrun bits (a same-cycle set wins)

module edge_event_arbiter
   import edge_arb_pkg::*;
#(
   parameter int N   = EDGE_ARB_N_DEFAULT,
   parameter int IDW = $clog2(N)
) (
   input  logic           clk_i,
   input  logic           reset_i,
   input  logic [N-1:0]   level_i,
   output logic           ev_valid_o,
   output logic [IDW-1:0] ev_id_o,
   input  logic           ev_ready_i,
   output logic [N-1:0]   overrun_o,
   input  logic           clr_overrun_i
);

   logic [N-1:0]   tick;

   arb_state_e     arb_q, arb_d;
   logic [IDW-1:0] ev_id_q, ev_id_d;
   logic [IDW-1:0] rr_q, rr_d;
   logic [N-1:0]   pend_q, pend_d;
   logic [N-1:0]   ovr_q, ovr_d;

   logic           accept;
   logic [N-1:0]   accept_vec;
   logic [N-1:0]   ovr_set;
   logic [IDW-1:0] next_ptr;

   logic [2*N-1:0] pend_dbl;
   logic [N-1:0]   pend_rot;
   logic           sel_found;
   logic [IDW-1:0] sel_idx;
   logic [IDW:0]   sel_sum;

   for (genvar g = 0; g < N; g++) begin : g_det
      edge_detect_cell u_det (
         .clk_i   (clk_i),
         .reset_i (reset_i),
         .level_i (level_i[g]),
         .tick_o  (tick[g])
      );
   end

   assign accept     = (arb_q == OFFER) && ev_ready_i;
   assign accept_vec = accept ? (N'(1) << ev_id_q) : '0;

   // A tick on the channel being accepted re-arms pending without overrun.
   assign pend_d  = tick | (pend_q & ~accept_vec);
   assign ovr_set = tick & pend_q & ~accept_vec;
   assign ovr_d   = ovr_set | (ovr_q & ~{N{clr_overrun_i}});

   assign next_ptr = (ev_id_q == IDW'(N - 1)) ? '0 : ev_id_q + IDW'(1);

   // Rotate pending so bit 0 corresponds to the rr pointer, find the first
   // set bit, then map the offset back to an absolute channel index mod N.
   always_comb begin
      pend_dbl  = {pend_q, pend_q} >> rr_q;
      pend_rot  = pend_dbl[N-1:0];
      sel_found = 1'b0;
      sel_idx   = '0;
      sel_sum   = '0;
      for (int k = 0; k < N; k++) begin
         if (!sel_found && pend_rot[k]) begin
            sel_found = 1'b1;
            sel_sum   = {1'b0, rr_q} + (IDW+1)'(k);
            if (sel_sum >= (IDW+1)'(N)) begin
               sel_sum = sel_sum - (IDW+1)'(N);
            end
            sel_idx = sel_sum[IDW-1:0];
         end
      end
   end

   always_comb begin
      arb_d   = arb_q;
      ev_id_d = ev_id_q;
      rr_d    = rr_q;
      case (arb_q)
         IDLE: begin
            if (sel_found) begin
               ev_id_d = sel_idx;
               arb_d   = OFFER;
            end
         end
         OFFER: begin
            if (ev_ready_i) begin
               rr_d  = next_ptr;
               arb_d = IDLE;
            end
         end
         default: arb_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         arb_q   <= IDLE;
         ev_id_q <= '0;
         rr_q    <= '0;
         pend_q  <= '0;
         ovr_q   <= '0;
      end else begin
         arb_q   <= arb_d;
         ev_id_q <= ev_id_d;
         rr_q    <= rr_d;
         pend_q  <= pend_d;
         ovr_q   <= ovr_d;
      end
   end

   assign ev_valid_o = (arb_q == OFFER);
   assign ev_id_o    = ev_id_q;
   assign overrun_o  = ovr_q;

endmodule : edge_event_arbiter

// File: tb/tb_edge_event_arbiter.sv
module tb_edge_event_arbiter;

   localparam int N   = 4;
   localparam int IDW = 2;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   level;
   logic           ready;
   logic           clr;
   logic           dut_valid;
   logic [IDW-1:0] dut_id;
   logic [N-1:0]   dut_ovr;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   edge_event_arbiter #(.N(N), .IDW(IDW)) dut (
      .clk_i         (clk),
      .reset_i       (rst),
      .level_i       (level),
      .ev_valid_o    (dut_valid),
      .ev_id_o       (dut_id),
      .ev_ready_i    (ready),
      .overrun_o     (dut_ovr),
      .clr_overrun_i (clr)
   );

   // Reference model: edges as sample arithmetic, pending as a bit set,
   // arbiter as "offer / not offering" plus a search pointer.
   logic [N-1:0] m_prev, m_prev2, m_pend, m_ovr;
   logic         m_valid;
   int           m_id, m_rr;

   function automatic void model_edge(input logic r, input logic [N-1:0] l,
                                      input logic rd, input logic c);
      logic [N-1:0] edge_now, new_pend, set;
      if (r) begin
         m_prev = '0; m_prev2 = '0; m_pend = '0; m_ovr = '0;
         m_valid = 1'b0; m_id = 0; m_rr = 0;
         return;
      end
      edge_now = m_prev & ~m_prev2;
      new_pend = '0;
      set      = '0;
      for (int i = 0; i < N; i++) begin
         bit taken;
         taken = m_valid && rd && (m_id == i);
         if (edge_now[i] && m_pend[i] && !taken) set[i] = 1'b1;
         new_pend[i] = edge_now[i] || (m_pend[i] && !taken);
      end
      m_ovr = set | (c ? '0 : m_ovr);
      if (m_valid) begin
         if (rd) begin
            m_valid = 1'b0;
            m_rr    = (m_id + 1) % N;
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            if (!m_valid && m_pend[(m_rr + k) % N]) begin
               m_valid = 1'b1;
               m_id    = (m_rr + k) % N;
            end
         end
      end
      m_pend  = new_pend;
      m_prev2 = m_prev;
      m_prev  = l;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic [N-1:0] l, input logic rd, input logic c);
      rst = r; level = l; ready = rd; clr = c;
      @(posedge clk);
      model_edge(r, l, rd, c);
      @(negedge clk);
      check("model_valid", 32'(dut_valid), 32'(m_valid));
      check("model_overrun", 32'(dut_ovr), 32'(m_ovr));
      if (m_valid) check("model_id", 32'(dut_id), 32'(m_id));
   endtask

   typedef struct {
      logic         rst;
      logic [N-1:0] lvl;
      logic         rdy;
      logic         clr;
      logic         exp_valid;
      int           exp_id;
      logic [N-1:0] exp_ovr;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic r, input logic [N-1:0] l, input logic rd,
                               input logic c, input logic ev, input int id,
                               input logic [N-1:0] ov);
      vec_t v;
      v.rst = r; v.lvl = l; v.rdy = rd; v.clr = c;
      v.exp_valid = ev; v.exp_id = id; v.exp_ovr = ov;
      vecs.push_back(v);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog time limit expired");
      $fatal(1);
   end

   initial begin
      int cnt, grants0, seen2, cnt2;
      logic [N-1:0] lv;

      rst = 1'b1; level = '0; ready = 1'b0; clr = 1'b0;

      // single edge on channel 2
      add(1, 4'b0000, 1, 0, 0, 0, 4'b0000);
      add(1, 4'b0000, 1, 0, 0, 0, 4'b0000);
      add(0, 4'b0100, 1, 0, 0, 0, 4'b0000);
      add(0, 4'b0100, 1, 0, 0, 0, 4'b0000);
      add(0, 4'b0100, 1, 0, 1, 2, 4'b0000);
      add(0, 4'b0100, 1, 0, 0, 0, 4'b0000);
      add(0, 4'b0000, 1, 0, 0, 0, 4'b0000);
      // all four channels together: 0,1,2,3 on alternating cycles
      add(1, 4'b0000, 1, 0, 0, 0, 4'b0000);
      add(1, 4'b0000, 1, 0, 0, 0, 4'b0000);
      add(0, 4'b1111, 1, 0, 0, 0, 4'b0000);
      add(0, 4'b1111, 1, 0, 0, 0, 4'b0000);
      add(0, 4'b1111, 1, 0, 1, 0, 4'b0000);
      add(0, 4'b1111, 1, 0, 0, 0, 4'b0000);
      add(0, 4'b1111, 1, 0, 1, 1, 4'b0000);
      add(0, 4'b1111, 1, 0, 0, 0, 4'b0000);
      add(0, 4'b1111, 1, 0, 1, 2, 4'b0000);
      add(0, 4'b1111, 1, 0, 0, 0, 4'b0000);
      add(0, 4'b1111, 1, 0, 1, 3, 4'b0000);
      add(0, 4'b1111, 1, 0, 0, 0, 4'b0000);
      add(0, 4'b0000, 1, 0, 0, 0, 4'b0000);
      // pointer back at 0: channels 1 and 3 together grant 1 first
      add(0, 4'b1010, 1, 0, 0, 0, 4'b0000);
      add(0, 4'b1010, 1, 0, 0, 0, 4'b0000);
      add(0, 4'b1010, 1, 0, 1, 1, 4'b0000);
      add(0, 4'b1010, 1, 0, 0, 0, 4'b0000);
      add(0, 4'b1010, 1, 0, 1, 3, 4'b0000);
      add(0, 4'b1010, 1, 0, 0, 0, 4'b0000);

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].lvl, vecs[i].rdy, vecs[i].clr);
         check($sformatf("tbl%0d_valid", i), 32'(dut_valid), 32'(vecs[i].exp_valid));
         check($sformatf("tbl%0d_overrun", i), 32'(dut_ovr), 32'(vecs[i].exp_ovr));
         if (vecs[i].exp_valid || vecs[i].rst)
            check($sformatf("tbl%0d_id", i), 32'(dut_id), 32'(vecs[i].exp_id));
      end

      // overrun on channel 1 while its offer is stalled
      step(1, 4'b0000, 0, 0); step(1, 4'b0000, 0, 0);
      repeat (3) step(0, 4'b0010, 0, 0);
      check("ovr_offer_valid", 32'(dut_valid), 32'd1);
      check("ovr_offer_id", 32'(dut_id), 32'd1);
      step(0, 4'b0000, 0, 0); step(0, 4'b0010, 0, 0);
      step(0, 4'b0000, 0, 0); step(0, 4'b0010, 0, 0);
      repeat (6) step(0, 4'b0010, 0, 0);
      check("ovr_set", 32'(dut_ovr), 32'h2);
      check("ovr_id_held", 32'(dut_id), 32'd1);
      check("ovr_still_valid", 32'(dut_valid), 32'd1);
      step(0, 4'b0010, 0, 1);
      check("ovr_cleared", 32'(dut_ovr), 32'h0);
      // set and clear in the same cycle: set wins
      step(0, 4'b0000, 0, 0);
      step(0, 4'b0010, 0, 0);
      step(0, 4'b0010, 0, 1);
      check("ovr_set_wins", 32'(dut_ovr), 32'h2);
      step(0, 4'b0010, 0, 1);
      check("ovr_clr_again", 32'(dut_ovr), 32'h0);
      repeat (3) step(0, 4'b0000, 1, 0);

      // channel 3 tick coincides with accept of its previous event
      step(1, 4'b0000, 0, 0);
      step(0, 4'b1000, 0, 0);
      step(0, 4'b1000, 0, 0);
      step(0, 4'b0000, 0, 0);
      check("c3_offer", 32'(dut_valid), 32'd1);
      step(0, 4'b1000, 0, 0);
      step(0, 4'b1000, 1, 0);
      check("c3_accepted", 32'(dut_valid), 32'd0);
      step(0, 4'b1000, 0, 0);
      check("c3_second_valid", 32'(dut_valid), 32'd1);
      check("c3_second_id", 32'(dut_id), 32'd3);
      check("c3_no_overrun", 32'(dut_ovr), 32'h0);
      step(0, 4'b1000, 1, 0);

      // level held high across reset release: exactly one event
      step(1, 4'b0001, 1, 0); step(1, 4'b0001, 1, 0);
      cnt = 0;
      repeat (8) begin
         step(0, 4'b0001, 1, 0);
         if (dut_valid) begin
            cnt++;
            check("held_id", 32'(dut_id), 32'd0);
         end
      end
      check("held_event_count", 32'(cnt), 32'd1);

      // reset during OFFER discards everything
      step(1, 4'b0000, 0, 0);
      repeat (3) step(0, 4'b0100, 0, 0);
      check("rst_pre_valid", 32'(dut_valid), 32'd1);
      step(1, 4'b0000, 0, 0);
      check("rst_valid", 32'(dut_valid), 32'd0);
      check("rst_id", 32'(dut_id), 32'd0);
      check("rst_ovr", 32'(dut_ovr), 32'h0);
      cnt = 0;
      repeat (4) begin
         step(0, 4'b0000, 1, 0);
         if (dut_valid) cnt++;
      end
      check("rst_pending_cleared", 32'(cnt), 32'd0);

      // channel 0 pulsing continuously, channel 2 one event
      step(1, 4'b0000, 1, 0); step(1, 4'b0000, 1, 0);
      grants0 = 0; seen2 = 0; cnt2 = 0;
      for (int t = 0; t < 24; t++) begin
         lv = '0;
         lv[0] = (t % 2 == 0);
         lv[2] = (t >= 2);
         step(0, lv, 1, 0);
         if (dut_valid && dut_id == 2) begin
            seen2 = 1; cnt2++;
         end else if (dut_valid && dut_id == 0 && seen2 == 0 && t >= 4) begin
            grants0++;
         end
      end
      check("rr_ch2_seen", 32'(seen2), 32'd1);
      check("rr_ch2_once", 32'(cnt2), 32'd1);
      check("rr_ch0_grants_before", 32'(grants0 <= 2), 32'd1);

      // randomized traffic against the model
      step(1, 4'b0000, 0, 0);
      lv = '0;
      for (int t = 0; t < 500; t++) begin
         for (int b = 0; b < N; b++)
            if ($urandom_range(0, 2) == 0) lv[b] = ~lv[b];
         step(($urandom_range(0, 63) == 0), lv, ($urandom_range(0, 2) != 0),
              ($urandom_range(0, 15) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_edge_event_arbiter
